// File: rtl/apb_pkg.sv
// Shared types and constants for the byte-wide APB completer and its register file.
package apb_pkg;

    localparam int APB_DW = 8;
    localparam int APB_AW = 8;

    localparam logic [APB_DW-1:0] APB_ERR_RDATA = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } apb_slv_state_t;

    // An address is in error when it lies at or beyond the implemented depth.
    function automatic logic addr_err(input logic [APB_AW-1:0] addr, input int depth);
        return (int'(addr) >= depth);
    endfunction

endpackage

// File: rtl/apb_slv_regfile.sv
// DEPTH x 8 byte storage: combinational read, clocked write, cleared by reset.
module apb_slv_regfile
    import apb_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              we,
    input  logic [APB_AW-1:0] waddr,
    input  logic [APB_DW-1:0] wdata,
    input  logic [APB_AW-1:0] raddr,
    output logic [APB_DW-1:0] rdata
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [APB_DW-1:0] mem_q [DEPTH];
    logic [IW-1:0]     widx_s;
    logic [IW-1:0]     ridx_s;

    assign widx_s = waddr[IW-1:0];
    assign ridx_s = raddr[IW-1:0];

    // Storage write; out-of-range addresses never reach the array.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {APB_DW{1'b0}};
            end
        end else if (we && !addr_err(waddr, DEPTH)) begin
            mem_q[widx_s] <= wdata;
        end
    end

    assign rdata = addr_err(raddr, DEPTH) ? APB_ERR_RDATA : mem_q[ridx_s];

endmodule

// File: rtl/apb_slave.sv
// APB completer: captures the setup phase, counts wait states, then issues a
// one-cycle registered PREADY with PSLVERR for addresses beyond DEPTH.
module apb_slave
    import apb_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PSEL,
    input  logic              PEN,
    input  logic              PWRITE,
    input  logic [APB_AW-1:0] PADDR,
    input  logic [APB_DW-1:0] PWDATA,
    output logic [APB_DW-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    // The counter holds the waits still to go after the current one.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    apb_slv_state_t    state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [APB_AW-1:0] addr_q, addr_d;
    logic [APB_DW-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic [APB_DW-1:0] prdata_q, prdata_d;

    logic              launch_s;
    logic              err_s;
    logic              we_s;
    logic [APB_DW-1:0] rdata_s;

    // Transfer sequencing and setup-phase capture.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        write_d  = write_q;
        launch_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (PSEL && !PEN) begin
                    addr_d  = PADDR;
                    wdata_d = PWDATA;
                    write_d = PWRITE;
                    if (WAIT_CYCLES == 0) begin
                        launch_s = 1'b1;
                        state_d  = RESP;
                    end else begin
                        cnt_d   = WAIT_LOAD;
                        state_d = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    launch_s = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign err_s = addr_err(addr_d, DEPTH);
    assign we_s  = (state_q == RESP) && PSEL && PEN && write_q && !addr_err(addr_q, DEPTH);

    // Response launched one edge ahead so PREADY/PSLVERR/PRDATA come straight from flops.
    always_comb begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = prdata_q;
        if (launch_s) begin
            pready_d  = 1'b1;
            pslverr_d = err_s;
            if (!write_d) begin
                prdata_d = err_s ? APB_ERR_RDATA : rdata_s;
            end else begin
                prdata_d = prdata_q;
            end
        end else begin
            pready_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
            write_q   <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    apb_slv_regfile #(
        .DEPTH (DEPTH)
    ) u_regfile (
        .CLK   (CLK),
        .RST   (RST),
        .we    (we_s),
        .waddr (addr_q),
        .wdata (wdata_q),
        .raddr (addr_d),
        .rdata (rdata_s)
    );

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

endmodule
